// File: rtl/draw_pkg.sv
// Shared types for draw_primitive_fetch: topology encodings, opcode and FSM states.
package draw_pkg;

    localparam logic [1:0] MODE_LIST    = 2'd0;
    localparam logic [1:0] MODE_STRIP   = 2'd1;
    localparam logic [1:0] MODE_FAN     = 2'd2;

    localparam logic [2:0] OPC_TRIANGLE = 3'd1;

    // Read tag: destination vertex (0=a, 1=b, 2=c) and component index.
    localparam int TAG_W = 4;

    typedef struct packed {
        logic [1:0] vtx;
        logic [1:0] comp;
    } tag_t;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_DRAIN     = 3'd2,
        S_DRAW      = 3'd3,
        S_WAIT_DRAW = 3'd4,
        S_FIN       = 3'd5
    } state_t;

endpackage

// File: rtl/draw_primitive_fetch_tracker.sv
// mem_read_tracker: follows each issued read through the memory latency so its data
// can be steered into the right vertex/component slot when it returns.
module mem_read_tracker #(
    parameter int MEM_LATENCY = 1,
    parameter int TAG_W       = 4
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             issue_i,
    input  logic [TAG_W-1:0] issue_tag_i,
    output logic             cap_o,
    output logic [TAG_W-1:0] cap_tag_o,
    output logic             empty_o
);

    logic [MEM_LATENCY-1:0] valid_q;
    logic [TAG_W-1:0]       tag_q [MEM_LATENCY];

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            valid_q <= '0;
            for (int i = 0; i < MEM_LATENCY; i++) tag_q[i] <= '0;
        end else begin
            valid_q[0] <= issue_i;
            tag_q[0]   <= issue_tag_i;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                tag_q[i]   <= tag_q[i-1];
            end
        end
    end

    assign cap_o     = valid_q[MEM_LATENCY-1];
    assign cap_tag_o = tag_q[MEM_LATENCY-1];

    // empty_o: nothing is queued behind the word currently being captured.
    always_comb begin
        empty_o = 1'b1;
        for (int i = 0; i < MEM_LATENCY - 1; i++) begin
            if (valid_q[i]) empty_o = 1'b0;
        end
    end

endmodule

// File: rtl/draw_primitive_fetch.sv
// Triangle fetch sequencer: list/strip/fan assembly with pipelined vertex/colour reads.
// Optional STRIP_WINDING_FIX_EN swaps a/b outputs on odd strip triangles.
module draw_primitive_fetch
    import draw_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int COLOUR_WIDTH = 3,
    parameter int COORDS       = 3,
    parameter int MEM_LATENCY  = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [1:0]              mode,
    input  logic [WIDTH-1:0]        base_addr,
    input  logic [WIDTH-1:0]        count,
    output logic                    busy,
    output logic                    done,
    output logic [WIDTH-1:0]        mem_read_addr,
    input  logic [WIDTH-1:0]        mem_read_data,
    output logic [WIDTH-1:0]        mem_col_addr,
    input  logic [COLOUR_WIDTH-1:0] mem_col_data,
    output logic [2:0]              opcode,
    output logic [COORDS*WIDTH-1:0] vert_a,
    output logic [COORDS*WIDTH-1:0] vert_b,
    output logic [COORDS*WIDTH-1:0] vert_c,
    output logic [COLOUR_WIDTH-1:0] colour,
    output logic                    draw_en,
    input  logic                    draw_done,
    output state_t                  dbg_state
);

    localparam logic [1:0] LAST_COMP = 2'(COORDS - 1);

    state_t                  state_q;
    logic [1:0]              mode_q;
    logic [WIDTH-1:0]        count_q, tri_q, vptr_q, tri_d;
    logic [1:0]              vtx_q, comp_q;
    logic [COORDS*WIDTH-1:0] va_q, vb_q, vc_q;
    logic [COLOUR_WIDTH-1:0] colour_q;
    logic                    busy_q, done_q, draw_en_q;
    logic                    issue, cap, trk_empty, swap;
    logic [TAG_W-1:0]        cap_tag_bits;
    tag_t                    cap_tag;

    assign issue   = (state_q == S_ISSUE);
    assign tri_d   = tri_q + WIDTH'(1);
    assign cap_tag = tag_t'(cap_tag_bits);

    mem_read_tracker #(
        .MEM_LATENCY(MEM_LATENCY),
        .TAG_W      (TAG_W)
    ) u_tracker (
        .clock_i    (clock),
        .reset_i    (reset),
        .issue_i    (issue),
        .issue_tag_i({vtx_q, comp_q}),
        .cap_o      (cap),
        .cap_tag_o  (cap_tag_bits),
        .empty_o    (trk_empty)
    );

    // Handshake: draw_en is a one-cycle valid pulse; draw_done acts as the ready/ack and
    // is honoured only in WAIT_DRAW, so an ack coincident with draw_en is dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            mode_q    <= MODE_LIST;
            count_q   <= '0;
            tri_q     <= '0;
            vptr_q    <= '0;
            vtx_q     <= '0;
            comp_q    <= '0;
            va_q      <= '0;
            vb_q      <= '0;
            vc_q      <= '0;
            colour_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            draw_en_q <= 1'b0;
        end else begin
            draw_en_q <= 1'b0;
            done_q    <= 1'b0;

            for (int k = 0; k < COORDS; k++) begin
                if (cap && cap_tag.comp == 2'(k)) begin
                    case (cap_tag.vtx)
                        2'd0:    va_q[k*WIDTH +: WIDTH] <= mem_read_data;
                        2'd1:    vb_q[k*WIDTH +: WIDTH] <= mem_read_data;
                        default: vc_q[k*WIDTH +: WIDTH] <= mem_read_data;
                    endcase
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mode_q  <= (mode == MODE_STRIP || mode == MODE_FAN) ? mode : MODE_LIST;
                        count_q <= count;
                        tri_q   <= '0;
                        vptr_q  <= base_addr;
                        vtx_q   <= 2'd0;
                        comp_q  <= 2'd0;
                        busy_q  <= 1'b1;
                        state_q <= (count == '0) ? S_FIN : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (comp_q == LAST_COMP) begin
                        comp_q <= 2'd0;
                        vptr_q <= vptr_q + WIDTH'(COORDS);
                        if (vtx_q == 2'd2) state_q <= S_DRAIN;
                        else               vtx_q   <= vtx_q + 2'd1;
                    end else begin
                        comp_q <= comp_q + 2'd1;
                    end
                end
                S_DRAIN: begin
                    if (cap && trk_empty) begin
                        colour_q  <= mem_col_data;
                        draw_en_q <= 1'b1;
                        state_q   <= S_DRAW;
                    end
                end
                S_DRAW: state_q <= S_WAIT_DRAW;
                S_WAIT_DRAW: begin
                    if (draw_done) begin
                        tri_q <= tri_d;
                        if (tri_d == count_q) begin
                            state_q <= S_FIN;
                        end else begin
                            state_q <= S_ISSUE;
                            vtx_q   <= (mode_q == MODE_LIST) ? 2'd0 : 2'd2;
                            if (mode_q == MODE_STRIP) begin
                                va_q <= vb_q;
                                vb_q <= vc_q;
                            end else if (mode_q == MODE_FAN) begin
                                vb_q <= vc_q;
                            end
                        end
                    end
                end
                // done is registered, so the pulse appears the cycle after FIN.
                S_FIN: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef STRIP_WINDING_FIX_EN
    assign swap = (mode_q == MODE_STRIP) && tri_q[0];
`else
    assign swap = 1'b0;
`endif

    assign vert_a        = swap ? vb_q : va_q;
    assign vert_b        = swap ? va_q : vb_q;
    assign vert_c        = vc_q;
    assign colour        = colour_q;
    assign draw_en       = draw_en_q;
    assign done          = done_q;
    assign busy          = busy_q;
    assign opcode        = OPC_TRIANGLE;
    assign mem_col_addr  = tri_q;
    assign mem_read_addr = vptr_q + WIDTH'(comp_q);
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_draw_primitive_fetch.sv
// Bench for draw_primitive_fetch: a COORDS=3/latency-1 instance and a COORDS=2/latency-3 instance.
module tb_draw_primitive_fetch;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] col_of(input logic [31:0] a);
        logic [31:0] t;
        t = a * 3 + 2;
        return t[2:0];
    endfunction

    function automatic logic [95:0] vtx3(input logic [31:0] base, input int k);
        logic [31:0] b;
        b = base + 32'(3 * k);
        return {b + 32'd2, b + 32'd1, b};
    endfunction

    // ---------------- instance 0: COORDS=3, MEM_LATENCY=1 ----------------
    logic        start0 = 0, den0, ddone0 = 0, busy0, done0;
    logic [1:0]  mode0 = 0;
    logic [31:0] base0 = 0, count0 = 0, addr0, rdata0, caddr0;
    logic [2:0]  cdata0, opc0, col0, st0;
    logic [95:0] va0, vb0, vc0;

    draw_primitive_fetch #(.WIDTH(32), .COLOUR_WIDTH(3), .COORDS(3), .MEM_LATENCY(1)) dut0 (
        .clock(clock), .reset(reset), .start(start0), .mode(mode0), .base_addr(base0),
        .count(count0), .busy(busy0), .done(done0), .mem_read_addr(addr0),
        .mem_read_data(rdata0), .mem_col_addr(caddr0), .mem_col_data(cdata0),
        .opcode(opc0), .vert_a(va0), .vert_b(vb0), .vert_c(vc0), .colour(col0),
        .draw_en(den0), .draw_done(ddone0), .dbg_state(st0)
    );

    always @(posedge clock) begin
        rdata0 <= addr0;
        cdata0 <= col_of(caddr0);
    end

    // ---------------- instance 1: COORDS=2, MEM_LATENCY=3 ----------------
    logic        start1 = 0, den1, ddone1 = 1, busy1, done1;
    logic [1:0]  mode1 = 0;
    logic [31:0] base1 = 0, count1 = 0, addr1, rdata1, caddr1, mp1, mp2;
    logic [2:0]  cdata1, cp1, cp2, opc1, col1, st1;
    logic [63:0] va1, vb1, vc1;

    draw_primitive_fetch #(.WIDTH(32), .COLOUR_WIDTH(3), .COORDS(2), .MEM_LATENCY(3)) dut1 (
        .clock(clock), .reset(reset), .start(start1), .mode(mode1), .base_addr(base1),
        .count(count1), .busy(busy1), .done(done1), .mem_read_addr(addr1),
        .mem_read_data(rdata1), .mem_col_addr(caddr1), .mem_col_data(cdata1),
        .opcode(opc1), .vert_a(va1), .vert_b(vb1), .vert_c(vc1), .colour(col1),
        .draw_en(den1), .draw_done(ddone1), .dbg_state(st1)
    );

    always @(posedge clock) begin
        mp1    <= addr1;
        mp2    <= mp1;
        rdata1 <= mp2;
        cp1    <= col_of(caddr1);
        cp2    <= cp1;
        cdata1 <= cp2;
    end

    // ---------------- instance 0 monitor, rasteriser model, scoreboard ----------------
    logic [95:0] obs_a[$], obs_b[$], obs_c[$];
    logic [2:0]  obs_col[$];
    int          obs_p[$];
    int          c0 = 0, done_cnt0 = 0, done_p0 = 0;
    bit          auto0 = 1, spur0 = 0;

    initial forever begin
        @(negedge clock);
        if (den0) begin
            obs_a.push_back(va0);
            obs_b.push_back(vb0);
            obs_c.push_back(vc0);
            obs_col.push_back(col0);
            obs_p.push_back(cyc - c0 + 1);
        end
        if (done0) begin
            done_cnt0++;
            done_p0 = cyc - c0 + 1;
        end
    end

    initial forever begin
        @(negedge clock);
        if (auto0 && den0) begin
            ddone0 = spur0;
            @(negedge clock) ddone0 = 1'b0;
            @(negedge clock) ddone0 = 1'b1;
            @(negedge clock) ddone0 = 1'b0;
        end
    end

    task automatic clear0();
        obs_a.delete(); obs_b.delete(); obs_c.delete(); obs_col.delete(); obs_p.delete();
        done_cnt0 = 0;
        done_p0   = 0;
    endtask

    task automatic kick0(input logic [1:0] m, input logic [31:0] b, input logic [31:0] n);
        @(negedge clock);
        mode0 = m; base0 = b; count0 = n; start0 = 1'b1;
        @(posedge clock);
        #1 c0 = cyc;
        start0 = 1'b0;
    endtask

    task automatic wait_done0();
        for (int k = 0; k < 400 && done_cnt0 == 0; k++) @(negedge clock);
        repeat (8) @(negedge clock);
    endtask

    task automatic run0(input logic [1:0] m, input logic [31:0] b, input logic [31:0] n, input bit sp);
        clear0();
        spur0 = sp;
        kick0(m, b, n);
        wait_done0();
        check("batch_done_count", done_cnt0, 1);
    endtask

    logic [31:0] exp_q[$];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clock);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_draw_en", den0, 0);
        check("rst_opcode", opc0, 3'd1);
        check("rst_addr", addr0, 0);
        check("rst_vert_a", va0, 0);
        check("rst_state", st0, 3'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // List, base 100, two triangles
        run0(2'd0, 32'd100, 32'd2, 1'b0);
        check("list_ntri", obs_a.size(), 2);
        check("list_first_draw_cycle", obs_p[0], 11);
        check("list_a0", obs_a[0], {32'd102, 32'd101, 32'd100});
        check("list_b0", obs_b[0], {32'd105, 32'd104, 32'd103});
        check("list_c0", obs_c[0], {32'd108, 32'd107, 32'd106});
        check("list_a1", obs_a[1], {32'd111, 32'd110, 32'd109});
        check("list_c1", obs_c[1], {32'd117, 32'd116, 32'd115});
        check("list_col0", obs_col[0], 3'd2);
        check("list_col1", obs_col[1], 3'd5);
        check("list_second_draw_cycle", obs_p[1], 24);
        check("list_done_cycle", done_p0, 28);

        // Strip, base 20, three triangles, with an early ack during draw_en
        run0(2'd1, 32'd20, 32'd3, 1'b1);
        check("strip_ntri", obs_a.size(), 3);
        check("strip_second_draw_cycle", obs_p[1], 18);
        check("strip_a0", obs_a[0], vtx3(20, 0));
`ifdef STRIP_WINDING_FIX_EN
        check("strip_a1", obs_a[1], vtx3(20, 2));
        check("strip_b1", obs_b[1], vtx3(20, 1));
`else
        check("strip_a1", obs_a[1], vtx3(20, 1));
        check("strip_b1", obs_b[1], vtx3(20, 2));
`endif
        check("strip_c1", obs_c[1], vtx3(20, 3));
        check("strip_a2", obs_a[2], vtx3(20, 2));
        check("strip_b2", obs_b[2], vtx3(20, 3));
        check("strip_c2", obs_c[2], vtx3(20, 4));
        check("strip_col2", obs_col[2], 3'd0);

        // Fan, base 200, three triangles
        run0(2'd2, 32'd200, 32'd3, 1'b0);
        check("fan_ntri", obs_a.size(), 3);
        check("fan_a0", obs_a[0], vtx3(200, 0));
        check("fan_a1", obs_a[1], vtx3(200, 0));
        check("fan_b1", obs_b[1], vtx3(200, 2));
        check("fan_a2", obs_a[2], vtx3(200, 0));
        check("fan_b2", obs_b[2], vtx3(200, 3));
        check("fan_c2", obs_c[2], vtx3(200, 4));

        // Empty batch
        run0(2'd0, 32'd77, 32'd0, 1'b0);
        check("zero_ntri", obs_a.size(), 0);
        check("zero_done_cycle", done_p0, 2);

        // Mode 3 behaves as list; addresses wrap past 2^32
        run0(2'd3, 32'hFFFF_FFFC, 32'd2, 1'b0);
        check("wrap_ntri", obs_a.size(), 2);
        check("wrap_a0", obs_a[0], {32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFC});
        check("wrap_b0", obs_b[0], {32'd1, 32'd0, 32'hFFFF_FFFF});
        check("wrap_a1", obs_a[1], {32'd7, 32'd6, 32'd5});

        // Async reset while waiting on the rasteriser
        auto0 = 1'b0;
        clear0();
        kick0(2'd0, 32'd0, 32'd4);
        for (int k = 0; k < 100 && !den0; k++) @(negedge clock);
        @(negedge clock);
        check("rst_mid_state_before", st0, 3'd4);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_busy", busy0, 0);
        check("rst_mid_vert_a", va0, 0);
        check("rst_mid_vert_c", vc0, 0);
        check("rst_mid_colour", col0, 0);
        check("rst_mid_addr", addr0, 0);
        check("rst_mid_col_addr", caddr0, 0);
        check("rst_mid_opcode", opc0, 3'd1);
        check("rst_mid_state", st0, 3'd0);
        @(negedge clock) reset = 1'b0;
        @(negedge clock) ddone0 = 1'b1;
        @(negedge clock) ddone0 = 1'b0;
        repeat (20) @(negedge clock);
        check("rst_no_done", done_cnt0, 0);
        check("rst_ntri", obs_a.size(), 1);
        check("rst_idle", st0, 3'd0);

        // Clean batch afterwards; a start during busy must be ignored
        auto0 = 1'b1;
        clear0();
        kick0(2'd0, 32'd50, 32'd1);
        repeat (3) @(negedge clock);
        mode0 = 2'd2; base0 = 32'd999; count0 = 32'd0; start0 = 1'b1;
        @(negedge clock) start0 = 1'b0;
        wait_done0();
        repeat (20) @(negedge clock);
        check("clean_done_count", done_cnt0, 1);
        check("clean_ntri", obs_a.size(), 1);
        check("clean_draw_cycle", obs_p[0], 11);
        check("clean_a0", obs_a[0], vtx3(50, 0));
        check("clean_c0", obs_c[0], vtx3(50, 2));

        // Instance 1: COORDS=2, MEM_LATENCY=3, one list triangle at base 40
        begin
            int c1, pd, pdone;
            check("l3_rst_opcode", opc1, 3'd1);
            for (int i = 0; i < 6; i++) exp_q.push_back(32'd40 + 32'(i));
            @(negedge clock);
            mode1 = 2'd0; base1 = 32'd40; count1 = 32'd1; start1 = 1'b1;
            @(posedge clock);
            #1 c1 = cyc;
            start1 = 1'b0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clock);
                check("l3_issue_addr", addr1, exp_q.pop_front());
            end
            pd = 0;
            for (int k = 0; k < 40 && pd == 0; k++) begin
                @(negedge clock);
                if (den1) pd = cyc - c1 + 1;
            end
            check("l3_draw_cycle", pd, 10);
            check("l3_a", va1, {32'd41, 32'd40});
            check("l3_b", vb1, {32'd43, 32'd42});
            check("l3_c", vc1, {32'd45, 32'd44});
            check("l3_colour", col1, 3'd2);
            pdone = 0;
            for (int k = 0; k < 40 && pdone == 0; k++) begin
                @(negedge clock);
                if (done1) pdone = cyc - c1 + 1;
            end
            check("l3_done_cycle", pdone, 13);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
